// File: rtl/fetch_ctrl_pkg.sv
// Shared definitions for the instruction-fetch controller: default widths,
// reset address and the fetch FSM state encoding.
package fetch_ctrl_pkg;

    localparam int unsigned ADDR_W_DEF     = 16;
    localparam int unsigned INSTR_W_DEF    = 16;
    localparam logic [15:0] RESET_ADDR_DEF = 16'h0000;

    typedef logic [1:0] fsm_state_t;

    localparam fsm_state_t ST_INIT     = 2'd0;
    localparam fsm_state_t ST_FETCH    = 2'd1;
    localparam fsm_state_t ST_HOLD     = 2'd2;
    localparam fsm_state_t ST_REDIRECT = 2'd3;

endpackage

// File: rtl/fetch_ctrl_buf.sv
// Holding register for one fetched instruction and its address, with
// valid/ready hand-off to the decoder and a flush for redirects.
module fetch_ctrl_buf #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic              ready,
    input  logic              flush,
    output logic              valid,
    output logic [DATA_W-1:0] data,
    output logic [ADDR_W-1:0] addr
);

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q,  data_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;

    // Flush wins over a simultaneous hand-off so a dropped word is never counted as taken.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        addr_d  = addr_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (load) begin
            valid_d = 1'b1;
            data_d  = load_data;
            addr_d  = load_addr;
        end else if (valid_q && ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            addr_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            addr_q  <= addr_d;
        end
    end

    assign valid = valid_q;
    assign data  = data_q;
    assign addr  = addr_q;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller: steers the PC via load/increment strobes,
// fetches through mem req/ack and hands words to decode via valid/ready.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter int unsigned       ADDR_W     = ADDR_W_DEF,
    parameter int unsigned       INSTR_W    = INSTR_W_DEF,
    parameter logic [ADDR_W-1:0] RESET_ADDR = RESET_ADDR_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [ADDR_W-1:0]  pc_count,
    output logic               pc_load,
    output logic               pc_increment,
    output logic [ADDR_W-1:0]  pc_target,
    output logic               mem_req,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic               mem_ack,
    input  logic [INSTR_W-1:0] mem_rdata,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_addr,
    input  logic               branch_valid,
    input  logic [ADDR_W-1:0]  branch_target
);

    fsm_state_t state_q, state_d;
    logic       branch_take;
    logic       buf_load;
    logic       buf_ready;
    logic       buf_flush;

    assign branch_take = !rst && branch_valid && (state_q != ST_INIT);
    assign mem_addr    = pc_count;

    // Reset masks every strobe so an abort never moves the PC or issues a request.
    always_comb begin
        state_d      = state_q;
        pc_load      = 1'b0;
        pc_increment = 1'b0;
        pc_target    = RESET_ADDR;
        mem_req      = 1'b0;
        buf_load     = 1'b0;
        buf_ready    = 1'b0;
        buf_flush    = 1'b0;
        if (rst) begin
            state_d = ST_INIT;
        end else if (branch_take) begin
            pc_load   = 1'b1;
            pc_target = branch_target;
            buf_flush = 1'b1;
            state_d   = ST_REDIRECT;
        end else begin
            unique case (state_q)
                ST_INIT: begin
                    pc_load = 1'b1;
                    state_d = ST_FETCH;
                end
                ST_FETCH: begin
                    mem_req = 1'b1;
                    if (mem_ack) begin
                        pc_increment = 1'b1;
                        buf_load     = 1'b1;
                        state_d      = ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (instr_ready) begin
                        buf_ready = 1'b1;
                        state_d   = ST_FETCH;
                    end
                end
                ST_REDIRECT: begin
                    state_d = ST_FETCH;
                end
                default: begin
                    state_d = ST_INIT;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    fetch_ctrl_buf #(
        .DATA_W (INSTR_W),
        .ADDR_W (ADDR_W)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .load      (buf_load),
        .load_data (mem_rdata),
        .load_addr (pc_count),
        .ready     (buf_ready),
        .flush     (buf_flush),
        .valid     (instr_valid),
        .data      (instr),
        .addr      (instr_addr)
    );

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed then randomized bench for fetch_ctrl against a transaction-level
// reference model, with a simple PC and a memory returning addr ^ A5A5.
module tb_fetch_ctrl;

    localparam logic [15:0] RESET_ADDR = 16'h0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] pc_count = 16'h1111;
    logic        pc_load;
    logic        pc_increment;
    logic [15:0] pc_target;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [15:0] mem_rdata;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [15:0] instr;
    logic [15:0] instr_addr;
    logic        branch_valid = 1'b0;
    logic [15:0] branch_target = 16'h0000;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    // Reference model: what the fetch path should be doing, in its own terms.
    bit          m_booting = 1'b0;
    bit          m_bubble  = 1'b0;
    bit          m_holding = 1'b0;
    bit          m_known   = 1'b0;
    logic [15:0] m_pc      = 16'h1111;
    logic [15:0] m_instr   = 16'h0000;
    logic [15:0] m_iaddr   = 16'h0000;

    fetch_ctrl #(
        .ADDR_W     (16),
        .INSTR_W    (16),
        .RESET_ADDR (RESET_ADDR)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .pc_count      (pc_count),
        .pc_load       (pc_load),
        .pc_increment  (pc_increment),
        .pc_target     (pc_target),
        .mem_req       (mem_req),
        .mem_addr      (mem_addr),
        .mem_ack       (mem_ack),
        .mem_rdata     (mem_rdata),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .instr         (instr),
        .instr_addr    (instr_addr),
        .branch_valid  (branch_valid),
        .branch_target (branch_target)
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem_addr ^ 16'hA5A5;

    always @(posedge clk) begin
        if (pc_load)
            pc_count <= pc_target;
        else if (pc_increment)
            pc_count <= pc_count + 16'd1;
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cycle(input bit r, input bit bv, input logic [15:0] bt,
                         input bit rdy, input bit ack);
        bit          e_load;
        bit          e_inc;
        bit          e_req;
        logic [15:0] e_tgt;
        rst           = r;
        branch_valid  = bv;
        branch_target = bt;
        instr_ready   = rdy;
        mem_ack       = ack;
        @(negedge clk);
        e_load = 1'b0;
        e_inc  = 1'b0;
        e_req  = 1'b0;
        e_tgt  = RESET_ADDR;
        if (r) begin
        end else if (m_booting) begin
            e_load = 1'b1;
        end else if (bv) begin
            e_load = 1'b1;
            e_tgt  = bt;
        end else if (m_bubble || m_holding) begin
        end else begin
            e_req = 1'b1;
            e_inc = ack;
        end
        check("pc_load", 16'(pc_load), 16'(e_load));
        check("pc_increment", 16'(pc_increment), 16'(e_inc));
        check("mem_req", 16'(mem_req), 16'(e_req));
        check("pc_count", pc_count, m_pc);
        if (e_load) check("pc_target", pc_target, e_tgt);
        if (e_req) check("mem_addr", mem_addr, m_pc);
        if (m_known) begin
            check("instr_valid", 16'(instr_valid), 16'(m_holding));
            check("instr", instr, m_instr);
            check("instr_addr", instr_addr, m_iaddr);
        end
        @(posedge clk);
        if (r) begin
            m_booting = 1'b1;
            m_bubble  = 1'b0;
            m_holding = 1'b0;
            m_instr   = 16'h0000;
            m_iaddr   = 16'h0000;
            m_known   = 1'b1;
        end else if (m_booting) begin
            m_booting = 1'b0;
            m_pc      = RESET_ADDR;
        end else if (bv) begin
            m_bubble  = 1'b1;
            m_holding = 1'b0;
            m_pc      = bt;
        end else if (m_bubble) begin
            m_bubble = 1'b0;
        end else if (m_holding) begin
            if (rdy) m_holding = 1'b0;
        end else if (ack) begin
            m_holding = 1'b1;
            m_instr   = m_pc ^ 16'hA5A5;
            m_iaddr   = m_pc;
            m_pc      = m_pc + 16'd1;
        end
        #1;
    endtask

    initial begin
        // reset, then zero-wait memory delivering 0000..0002
        repeat (2) cycle(1'b1, 1'b0, 16'h0, 1'b1, 1'b0);
        repeat (7) cycle(1'b0, 1'b0, 16'h0, 1'b1, 1'b1);
        // fetch 0003, then decoder stall for 5 cycles
        cycle(1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
        repeat (5) cycle(1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
        // three wait states on the fetch of 0004
        repeat (3) cycle(1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 16'h0, 1'b1, 1'b1);
        // branch while holding with ready high
        cycle(1'b0, 1'b1, 16'h1234, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 16'h0, 1'b1, 1'b1);
        cycle(1'b0, 1'b0, 16'h0, 1'b1, 1'b1);
        cycle(1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
        // branch colliding with an ack, to FFFF, then wrap to 0000
        cycle(1'b0, 1'b1, 16'hFFFF, 1'b1, 1'b1);
        repeat (6) cycle(1'b0, 1'b0, 16'h0, 1'b1, 1'b1);
        // reset mid-fetch, then restart
        cycle(1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
        cycle(1'b1, 1'b0, 16'h0, 1'b1, 1'b1);
        repeat (4) cycle(1'b0, 1'b1, 16'h4444, 1'b1, 1'b1);
        // randomized traffic
        repeat (3000) begin
            bit          r;
            bit          bv;
            logic [15:0] bt;
            r  = ($urandom_range(0, 99) == 0);
            bv = ($urandom_range(0, 11) == 0);
            bt = ($urandom_range(0, 3) == 0) ? 16'hFFFE + 16'($urandom_range(0, 1))
                                             : 16'($urandom);
            cycle(r, bv, bt, $urandom_range(0, 9) < 6, $urandom_range(0, 1) == 1);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Instruction-fetch controller that drives the program counter's `load`/`increment` controls and consumes its 16-bit `count`. It reads instruction memory at the current PC through a req/ack handshake and presents each fetched word to the decoder through a valid/ready handshake. It also redirects the PC on branches. It sits between `pc`, instruction memory and the decode stage.

## Interface
- `ADDR_W`, 16, PC/address width (matches `pc` count width)
- `INSTR_W`, 16, instruction word width
- `RESET_ADDR`, 16'h0000, address loaded into PC after reset
- `clk` in 1 — single clock, all state updates on rising edge
- `rst` in 1 — synchronous, active-high reset
- `pc_count` in ADDR_W — current PC value from `pc`
- `pc_load` out 1 — PC load strobe (one cycle)
- `pc_increment` out 1 — PC increment strobe (one cycle)
- `pc_target` out ADDR_W — load value for PC; meaningful only when `pc_load`=1
- `mem_req` out 1 — instruction memory read request
- `mem_addr` out ADDR_W — read address, equals `pc_count` while `mem_req`=1
- `mem_ack` in 1 — memory response valid; only honoured while `mem_req`=1
- `mem_rdata` in INSTR_W — instruction word, valid with `mem_ack`
- `instr_valid` out 1 — fetched instruction available to decoder
- `instr_ready` in 1 — decoder accepts instruction
- `instr` out INSTR_W — fetched instruction word (registered)
- `instr_addr` out ADDR_W — address the instruction was fetched from (registered)
- `branch_valid` in 1 — redirect request, one-cycle pulse
- `branch_target` in ADDR_W — redirect address

## Operation
- FSM states: INIT, FETCH, HOLD, REDIRECT.
- INIT: entered on `rst`. Drives `pc_load`=1 and `pc_target`=RESET_ADDR for one cycle, then goes to FETCH.
- FETCH:
  - `mem_req`=1 and `mem_addr`=`pc_count`.
  - On `mem_ack`: capture `mem_rdata`→`instr` and `pc_count`→`instr_addr`, pulse `pc_increment`, go to HOLD.
  - Without `mem_ack`: stay in FETCH with the request held and the address stable.
- HOLD:
  - `instr_valid`=1; `instr` and `instr_addr` stay stable.
  - On `instr_ready`: go to FETCH; `instr_valid` drops next cycle.
- Branch handling:
  - `branch_valid` in FETCH, HOLD or REDIRECT has priority over everything else. Drive `pc_load`=1, `pc_target`=`branch_target`, `pc_increment`=0, `mem_req`=0, then go to REDIRECT.
  - A `mem_ack` in the same cycle is discarded.
  - A held instruction is dropped: `instr_valid`=0 from the next cycle, and the handshake is not completed even if `instr_ready`=1.
- REDIRECT: one bubble cycle so `pc_count` reflects the new target. `mem_req`=0, then go to FETCH.
- `branch_valid` during INIT is ignored.
- `pc_load` and `pc_increment` are never both 1.
- Address wrap: FFFF+1 → 0000 is handled by `pc`; the controller follows `pc_count` without special-casing it.

## Timing
- Reset values:
  - state=INIT
  - `pc_load`=0 during the `rst` cycle, then 1 in the first INIT cycle
  - `pc_increment`=0, `pc_target`=RESET_ADDR
  - `mem_req`=0, `mem_addr`=`pc_count`
  - `instr_valid`=0, `instr`=0, `instr_addr`=0
- `rst` asserted mid-fetch or mid-hold aborts immediately: `instr_valid`=0 and `mem_req`=0 next cycle, with no PC strobe.
- Fetch latency: first `mem_req` appears 2 cycles after `rst` deasserts (INIT, then FETCH). With zero-wait memory, `instr_valid` rises 1 cycle after the ack cycle.
- Peak throughput: one instruction per 2 cycles (FETCH→HOLD→FETCH) with `instr_ready` held high.
- Branch-to-first-request penalty: 2 cycles (branch cycle plus REDIRECT).
- Strobe outputs are combinational from state and inputs. `instr`, `instr_addr` and `instr_valid` are registered.

## Structure
- The shared package holds:
  - the state encoding (INIT, FETCH, HOLD, REDIRECT as localparams)
  - default widths ADDR_W=16, INSTR_W=16 and RESET_ADDR, shared with `pc` and decode
- Optional sub-module `fetch_buf`: the instruction/address holding register with valid/ready/flush control.
- FSM and strobe logic stay in `fetch_ctrl`.

## Test plan
- Reset then zero-wait memory:
  - stimulus: `rst`=1 for 2 cycles, then release; memory returns rdata = addr^16'hA5A5
  - required: one `pc_load` to 0000; words A5A5, A5A4 and A5A7 delivered with `instr_addr` 0000, 0001 and 0002
- Decoder stall:
  - stimulus: `instr_ready`=0 for 5 cycles while holding the instruction from 0003
  - required: `instr`/`instr_addr` stable, no `pc_increment`, no `mem_req`; resumes at 0004
- Memory wait states:
  - stimulus: `mem_ack` delayed 3 cycles
  - required: `mem_req` held, `mem_addr` stable, exactly one `pc_increment`
- Branch in HOLD:
  - stimulus: `branch_valid` with `branch_target`=0x1234 while `instr_valid`=1 and `instr_ready`=1 in the same cycle
  - required: instruction dropped, `pc_load`/`pc_target`=1234, one bubble cycle, next fetch at 1234
- Branch colliding with ack in FETCH:
  - required: ack discarded, no `pc_increment`, redirect wins
- Wrap-around:
  - stimulus: branch to FFFF
  - required: fetch FFFF, then 0000
- Reset mid-fetch:
  - required: `instr_valid` and `mem_req` cleared next cycle; restart at RESET_ADDR
